// File: rtl/ps2_host_tx_if.sv
// PS/2 host transmitter bundle: source FIFO pop side, raw PS/2 line levels,
// open-drain line enables and per-byte status.
interface ps2_host_tx_if;
  logic       buf_empty;
  logic [7:0] buf_out;
  logic       rd_en;
  logic       ps2_clk_in;
  logic       ps2_data_in;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_err;

  // Transmitter side
  modport master (
    input  buf_empty, buf_out, ps2_clk_in, ps2_data_in,
    output rd_en, ps2_clk_oe, ps2_data_oe, tx_busy, tx_done, tx_err
  );

  // FIFO / line / status-consumer side
  modport slave (
    output buf_empty, buf_out, ps2_clk_in, ps2_data_in,
    input  rd_en, ps2_clk_oe, ps2_data_oe, tx_busy, tx_done, tx_err
  );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter. Pops one byte from a FIFO, inhibits the
// bus, issues request-to-send, then shifts data/parity/stop out on the
// device-generated falling clock edges and waits for the bus to go idle.
// Optional feature: define PS2_TX_ACK_CHECK_EN to require the device ack
// (data low at falling edge 11); otherwise edge 11 is consumed unchecked.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYC = 10000,
  parameter int unsigned TIMEOUT_CYC = 1500000
) (
  input logic           clk,
  input logic           rst,
  ps2_host_tx_if.master bus
);

  typedef enum logic [3:0] {
    StIdle,
    StPop,
    StLoad,
    StInhibit,
    StReq,
    StData,
    StParity,
    StStop,
    StAck,
    StWaitIdle
  } state_e;

  localparam int unsigned InhW = ($clog2(INHIBIT_CYC + 1) < 1) ? 1 : $clog2(INHIBIT_CYC + 1);
  localparam logic [InhW-1:0] InhLast = InhW'(INHIBIT_CYC - 1);
  localparam logic [20:0] TimeoutVal = 21'(TIMEOUT_CYC);

  state_e          state_q;
  logic            rd_en_q;
  logic            clk_oe_q;
  logic            data_oe_q;
  logic            busy_q;
  logic            done_q;
  logic            err_q;
  logic [7:0]      shift_q;
  logic            parity_q;
  logic [2:0]      bit_cnt_q;
  logic [InhW-1:0] inh_cnt_q;
  logic [20:0]     to_cnt_q;
  logic            ack_ok_q;

  logic [1:0]      clk_sync_q;
  logic [1:0]      data_sync_q;
  logic            clk_prev_q;

  logic            clk_s;
  logic            data_s;
  logic            clk_fall;
  logic            in_frame;
  logic            to_expired;
  logic            to_sat;

  assign clk_s      = clk_sync_q[1];
  assign data_s     = data_sync_q[1];
  assign clk_fall   = clk_prev_q & ~clk_s;
  // Timeout window covers everything after clock release up to the ack edge
  assign in_frame   = (state_q == StData) || (state_q == StParity) ||
                      (state_q == StStop) || (state_q == StAck);
  assign to_expired = (to_cnt_q >= TimeoutVal);
  assign to_sat     = &to_cnt_q;

  assign bus.rd_en       = rd_en_q;
  assign bus.ps2_clk_oe  = clk_oe_q;
  assign bus.ps2_data_oe = data_oe_q;
  assign bus.tx_busy     = busy_q;
  assign bus.tx_done     = done_q;
  assign bus.tx_err      = err_q;

  // Two-flop line synchronizers plus a delayed clock sample for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], bus.ps2_clk_in};
      data_sync_q <= {data_sync_q[0], bus.ps2_data_in};
      clk_prev_q  <= clk_sync_q[1];
    end
  end

  // Transmit sequencer with registered line enables and status pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      rd_en_q   <= 1'b0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      shift_q   <= 8'h00;
      parity_q  <= 1'b0;
      bit_cnt_q <= 3'd0;
      inh_cnt_q <= '0;
      to_cnt_q  <= 21'd0;
      ack_ok_q  <= 1'b0;
    end else begin
      rd_en_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      if (in_frame && !to_sat) begin
        to_cnt_q <= to_cnt_q + 21'd1;
      end

      if (in_frame && to_expired) begin
        // Device stopped clocking: drop the byte and free the bus
        clk_oe_q  <= 1'b0;
        data_oe_q <= 1'b0;
        err_q     <= 1'b1;
        busy_q    <= 1'b0;
        state_q   <= StIdle;
      end else begin
        case (state_q)
          StIdle: begin
            if (!bus.buf_empty) begin
              rd_en_q <= 1'b1;
              busy_q  <= 1'b1;
              state_q <= StPop;
            end
          end
          StPop: begin
            // FIFO presents the popped byte during the next cycle
            state_q <= StLoad;
          end
          StLoad: begin
            shift_q   <= bus.buf_out;
            parity_q  <= ~^bus.buf_out;
            inh_cnt_q <= '0;
            clk_oe_q  <= 1'b1;
            state_q   <= StInhibit;
          end
          StInhibit: begin
            if (inh_cnt_q == InhLast) begin
              data_oe_q <= 1'b1;
              state_q   <= StReq;
            end else begin
              inh_cnt_q <= inh_cnt_q + InhW'(1);
            end
          end
          StReq: begin
            // Start bit already on the line; hand the clock to the device
            clk_oe_q  <= 1'b0;
            to_cnt_q  <= 21'd0;
            bit_cnt_q <= 3'd0;
            state_q   <= StData;
          end
          StData: begin
            if (clk_fall) begin
              data_oe_q <= ~shift_q[0];
              shift_q   <= {1'b0, shift_q[7:1]};
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                state_q <= StParity;
              end
            end
          end
          StParity: begin
            if (clk_fall) begin
              data_oe_q <= ~parity_q;
              state_q   <= StStop;
            end
          end
          StStop: begin
            if (clk_fall) begin
              data_oe_q <= 1'b0;
              state_q   <= StAck;
            end
          end
          StAck: begin
            if (clk_fall) begin
`ifdef PS2_TX_ACK_CHECK_EN
              ack_ok_q <= ~data_s;
`else
              ack_ok_q <= 1'b1;
`endif
              state_q  <= StWaitIdle;
            end
          end
          StWaitIdle: begin
            if (clk_s && data_s) begin
              done_q  <= ack_ok_q;
              err_q   <= ~ack_ok_q;
              busy_q  <= 1'b0;
              state_q <= StIdle;
            end
          end
          default: begin
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: FIFO model, behavioural PS/2 device, scoreboard of
// expected per-byte results checked by an independent monitor.
module tb_ps2_host_tx;
  localparam int unsigned INH  = 20;
  localparam int unsigned TMO  = 400;
  localparam int          HALF = 10;

  // Device behaviour per frame
  localparam int ModeAck    = 0;
  localparam int ModeSilent = 1;
  localparam int ModeNoAck  = 2;
  localparam int ModeAbort4 = 3;

  typedef struct packed {
    logic [7:0] d;
    logic       err;
    logic       tmo;
    logic       chk;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ps2_host_tx_if bus ();

  ps2_host_tx #(
    .INHIBIT_CYC(INH),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- FIFO model ----------------
  logic [7:0] fifo_q[$];
  logic [7:0] buf_out_r = 8'h00;
  assign bus.buf_empty = (fifo_q.size() == 0);
  assign bus.buf_out   = buf_out_r;
  always @(posedge clk) begin
    if (bus.rd_en && fifo_q.size() > 0) buf_out_r <= fifo_q.pop_front();
  end

  // ---------------- PS/2 device model ----------------
  logic dev_clk_low  = 1'b0;
  logic dev_data_low = 1'b0;
  assign bus.ps2_clk_in  = ~(bus.ps2_clk_oe | dev_clk_low);
  assign bus.ps2_data_in = ~(bus.ps2_data_oe | dev_data_low);

  int         dev_mode    = ModeAck;
  logic [9:0] cap         = '0;
  bit         edge4_seen  = 1'b0;
  logic       dev_prev_oe = 1'b0;

  task automatic run_frame();
    cap = 'x;
    for (int n = 1; n <= 11; n++) begin
      if (n == 11 && dev_mode == ModeAck) dev_data_low = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b1;
      if (n == 4 && dev_mode == ModeAbort4) begin
        repeat (6) @(negedge clk);
        dev_clk_low = 1'b0;
        edge4_seen  = 1'b1;
        return;
      end
      repeat (HALF) @(negedge clk);
      // bit n-1 is on the line once the host has reacted to falling edge n
      if (n <= 10) cap[n-1] = bus.ps2_data_in;
      dev_clk_low = 1'b0;
    end
    repeat (4) @(negedge clk);
    dev_data_low = 1'b0;
  endtask

  initial begin : device
    forever begin
      @(negedge clk);
      // request-to-send: host releases clock while holding data low
      if (!rst && dev_prev_oe && !bus.ps2_clk_oe && bus.ps2_data_oe && dev_mode != ModeSilent)
        run_frame();
      dev_prev_oe = bus.ps2_clk_oe;
    end
  end

  // ---------------- Scoreboard monitor ----------------
  exp_t exp_q[$];
  int   cyc = 0, rel_cyc = 0, inh_n = 0, ovl_n = 0, pops_n = 0;
  logic prev_clk_oe = 1'b0;
  bit   in_flight = 1'b0;

  task automatic check_result();
    exp_t e;
    int   lat;
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL unexpected_result: got done=%0b err=%0b, expected no result",
               bus.tx_done, bus.tx_err);
      return;
    end
    e = exp_q.pop_front();
    check("result_done_err", {bus.tx_done, bus.tx_err}, e.err ? 2'b01 : 2'b10);
    check("pops_per_frame", pops_n, 1);
    check("lines_released", {bus.ps2_clk_oe, bus.ps2_data_oe}, 2'b00);
    check("busy_clear", bus.tx_busy, 1'b0);
    check("inhibit_cycles", inh_n, INH);
    check("start_overlap", ovl_n, 1);
    if (e.chk) begin
      check("data_bits", cap[7:0], e.d);
      check("parity_bit", cap[8], ($countones(e.d) % 2 == 0) ? 1'b1 : 1'b0);
      check("stop_bit", cap[9], 1'b1);
    end
    if (e.tmo) begin
      lat = cyc - rel_cyc;
      check("timeout_latency_ok", (lat >= int'(TMO) && lat <= int'(TMO) + 3), 1'b1);
    end
    pops_n    = 0;
    in_flight = 1'b0;
  endtask

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      in_flight   = 1'b0;
      pops_n      = 0;
      prev_clk_oe = 1'b0;
    end else begin
      if (bus.rd_en) begin
        check("no_pop_in_flight", in_flight, 1'b0);
        in_flight = 1'b1;
        pops_n++;
        inh_n = 0;
        ovl_n = 0;
      end
      if (bus.ps2_clk_oe && !bus.ps2_data_oe) inh_n++;
      if (bus.ps2_clk_oe && bus.ps2_data_oe) ovl_n++;
      if (prev_clk_oe && !bus.ps2_clk_oe) rel_cyc = cyc;
      prev_clk_oe = bus.ps2_clk_oe;
      if (bus.tx_done || bus.tx_err) check_result();
    end
  end

  // ---------------- Stimulus ----------------
  task automatic send(input logic [7:0] d, input int mode);
    exp_t e;
    e.d   = d;
    e.tmo = (mode == ModeSilent);
    e.chk = (mode != ModeSilent);
`ifdef PS2_TX_ACK_CHECK_EN
    e.err = (mode == ModeSilent) || (mode == ModeNoAck);
`else
    e.err = (mode == ModeSilent);
`endif
    dev_mode = mode;
    exp_q.push_back(e);
    fifo_q.push_back(d);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || bus.tx_busy) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check(name, (n < 5000), 1'b1);
    check({name, "_fifo_empty"}, fifo_q.size(), 0);
    repeat (5) @(negedge clk);
  endtask

  initial begin : main
    int quiet;
    int n;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_rd_en", bus.rd_en, 1'b0);
    check("rst_clk_oe", bus.ps2_clk_oe, 1'b0);
    check("rst_data_oe", bus.ps2_data_oe, 1'b0);
    check("rst_busy", bus.tx_busy, 1'b0);
    check("rst_done_err", {bus.tx_done, bus.tx_err}, 2'b00);
    rst = 1'b0;

    // Empty FIFO: nothing may move
    quiet = 0;
    repeat (200) begin
      @(negedge clk);
      if (bus.rd_en || bus.ps2_clk_oe || bus.ps2_data_oe || bus.tx_busy) quiet++;
    end
    check("idle_quiet", quiet, 0);

    send(8'hED, ModeAck);
    wait_drain("drain_ed");

    send(8'hFF, ModeAck);
    send(8'h01, ModeAck);
    wait_drain("drain_ff_01");

    for (int g = 0; g < 3; g++) begin
      send(8'($urandom_range(0, 255)), ModeAck);
      send(8'($urandom_range(0, 255)), ModeAck);
      wait_drain("drain_random");
    end

    send(8'h96, ModeNoAck);
    wait_drain("drain_noack");

    send(8'h3C, ModeSilent);
    wait_drain("drain_timeout");

    // Reset mid-frame after falling edge 4 of 0xAA
    edge4_seen = 1'b0;
    dev_mode   = ModeAbort4;
    fifo_q.push_back(8'hAA);
    n = 0;
    while (!edge4_seen && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("edge4_reached", edge4_seen, 1'b1);
    check("busy_before_rst", bus.tx_busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("rst_async_clk_oe", bus.ps2_clk_oe, 1'b0);
    check("rst_async_data_oe", bus.ps2_data_oe, 1'b0);
    check("rst_async_busy", bus.tx_busy, 1'b0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("abort_fifo_consumed", fifo_q.size(), 0);
    send(8'h5C, ModeAck);
    wait_drain("drain_after_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got no end of run, expected finish before 100000 cycles");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1);
  end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 The block SHALL have parameter INHIBIT_CYC, default 10000, giving the number of clk cycles ps2 clock is held low before the request (100 us at 100 MHz).
REQ-002 The block SHALL have parameter TIMEOUT_CYC, default 1500000, giving the clk cycles allowed from clock release to the ack phase ending.
REQ-003 The block SHALL have port clk  in  1  system clock, all logic on its rising edge.
REQ-004 The block SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port buf_empty  in  1  source FIFO empty flag.
REQ-006 The block SHALL have port buf_out  in  8  source FIFO data, valid the cycle after rd_en is sampled.
REQ-007 The block SHALL have port rd_en  out  1  single-cycle FIFO pop strobe.
REQ-008 The block SHALL have ports ps2_clk_in and ps2_data_in  in  1  raw PS/2 line levels.
REQ-009 The block SHALL have ports ps2_clk_oe and ps2_data_oe  out  1  1 = drive line low, 0 = release (open drain).
REQ-010 The block SHALL have port tx_busy  out  1  high from pop until return to IDLE.
REQ-011 The block SHALL have ports tx_done and tx_err  out  1  single-cycle result pulses.

Function
REQ-012 ps2_clk_in and ps2_data_in SHALL pass through 2-flop synchronizers; a falling edge is a registered synchronized sample going 1->0.
REQ-013 The FSM SHALL have states IDLE, POP, LOAD, INHIBIT, REQ, DATA, PARITY, STOP, ACK, WAIT_IDLE.
REQ-014 IDLE: when buf_empty=0, the FSM SHALL assert rd_en for exactly one cycle and go to POP.
REQ-015 POP->LOAD SHALL occur unconditionally; LOAD SHALL capture buf_out into the shift register and compute odd parity (parity = ~^data).
REQ-016 INHIBIT SHALL drive ps2_clk_oe=1 for INHIBIT_CYC cycles, then set ps2_data_oe=1 (start bit) and go to REQ.
REQ-017 REQ SHALL release ps2_clk_oe one cycle after data_oe asserts, keep data_oe=1, and start the timeout counter.
REQ-018 DATA: on each falling edge 1..8, ps2_data_oe SHALL become ~bit[n], LSB first; after the 8th it SHALL go to PARITY.
REQ-019 PARITY: on falling edge 9, ps2_data_oe SHALL become ~parity; then the FSM SHALL go to STOP.
REQ-020 STOP: on falling edge 10, ps2_data_oe SHALL become 0 (stop bit = released line); then the FSM SHALL go to ACK.
REQ-021 ACK: on falling edge 11, the FSM SHALL sample the ack (see Configuration) and go to WAIT_IDLE.
REQ-022 WAIT_IDLE: when both synchronized lines are high, the FSM SHALL pulse tx_done (or tx_err) and return to IDLE.
REQ-023 If the timeout counter reaches TIMEOUT_CYC in REQ..ACK, the block SHALL release both lines, pulse tx_err, discard the byte, and go to IDLE.
REQ-024 Falling edges seen in IDLE, POP, LOAD or INHIBIT SHALL be ignored.
REQ-025 No new pop SHALL occur until the FSM is back in IDLE, so at most one byte is in flight.
REQ-026 tx_busy SHALL be 1 in every state except IDLE.
REQ-027 The timeout counter SHALL be 21 bits wide and saturate, with no wrap-around.

Reset
REQ-028 While rst=1, the block SHALL hold state=IDLE, rd_en=0, ps2_clk_oe=0, ps2_data_oe=0, tx_busy=0, tx_done=0, tx_err=0, counters=0, synchronizers=1.
REQ-029 Reset asserted mid-frame SHALL release both lines immediately (asynchronously) and lose the byte; the FIFO SHALL NOT be re-read for it.

Configuration
REQ-030 With PS2_TX_ACK_CHECK_EN defined, ACK SHALL require synchronized data=0 at falling edge 11; data=1 SHALL yield tx_err instead of tx_done.
REQ-031 Without PS2_TX_ACK_CHECK_EN, edge 11 SHALL be consumed without checking and tx_done SHALL always pulse after WAIT_IDLE.

Verification
REQ-032 The bench SHALL check: FIFO holds 0xED; device model clocks 11 edges and acks -> one rd_en, INHIBIT_CYC cycles clk low, data bits 1,0,1,1,0,1,1,1, parity 1, stop released, tx_done=1.
REQ-033 The bench SHALL check: bytes 0xFF then 0x01 -> parity 1 then 0; two rd_en pulses, separated by a full frame; two tx_done pulses.
REQ-034 The bench SHALL check: buf_empty=1 throughout -> rd_en, ps2_clk_oe and ps2_data_oe stay 0; tx_busy=0.
REQ-035 The bench SHALL check: device never clocks after REQ -> tx_err at TIMEOUT_CYC+O(3) cycles, both oe=0, FSM in IDLE.
REQ-036 The bench SHALL check: with PS2_TX_ACK_CHECK_EN, the device leaves data high at edge 11 -> tx_err=1, tx_done=0; without the macro -> tx_done=1.
REQ-037 The bench SHALL check: rst pulsed after falling edge 4 of 0xAA -> both oe=0 within the reset cycle, tx_busy=0, the next FIFO byte is sent cleanly.
